// File: rtl/id_stage_pkg.sv
// Shared decode constants for the instruction-decode stage: opcodes,
// ALU command encoding, instruction field positions and immediate helpers.
package id_stage_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  typedef enum logic [3:0] {
    CMD_ADD = 4'd0,
    CMD_SUB = 4'd1,
    CMD_AND = 4'd2,
    CMD_OR  = 4'd3,
    CMD_NOR = 4'd4,
    CMD_XOR = 4'd5,
    CMD_SLA = 4'd6,
    CMD_SLL = 4'd7,
    CMD_SRA = 4'd8,
    CMD_SRL = 4'd9
  } ex_cmd_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int SRC1_MSB   = 25;
  localparam int SRC1_LSB   = 21;
  localparam int SRC2_MSB   = 20;
  localparam int SRC2_LSB   = 16;
  localparam int RDST_MSB   = 15;
  localparam int RDST_LSB   = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of fetch-side inputs, write-back port, branch redirect and the
// registered ID/EX outputs of the decode stage.
interface id_stage_if;

  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] ex_pc;
  logic [3:0]  ex_cmd;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_wb_en;
  logic [4:0]  ex_dest;
  logic [31:0] ex_val1;
  logic [31:0] ex_val2;
  logic [31:0] ex_st_val;

  modport slave (
    input  if_instruction, if_pc, wb_en, wb_dest, wb_value,
    output branch_taken, branch_address,
    output ex_pc, ex_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
    output ex_dest, ex_val1, ex_val2, ex_st_val
  );

  modport master (
    output if_instruction, if_pc, wb_en, wb_dest, wb_value,
    input  branch_taken, branch_address,
    input  ex_pc, ex_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
    input  ex_dest, ex_val1, ex_val2, ex_st_val
  );

endinterface

// File: rtl/id_stage_register_file.sv
// 32x32 register file, two combinational read ports and one write port.
// R0 is hardwired to zero; a same-cycle write is forwarded to the readers.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Write-before-read: the value being written this cycle wins over the array.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == 5'd0)
      rd_data1 = '0;
    else if (wr_en && (wr_addr == rd_addr1))
      rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == 5'd0)
      rd_data2 = '0;
    else if (wr_en && (wr_addr == rd_addr2))
      rd_data2 = wr_data;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, decoder, register file, branch
// resolution with one-instruction squash, and the registered ID/EX outputs.
module id_stage
  import id_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  logic [5:0]  opcode;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [4:0]  rdst;
  logic [31:0] imm_ext;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  ex_cmd_e     dec_cmd;
  logic        dec_r_type;
  logic        dec_use_imm;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_wb_en;
  logic [4:0]  dec_dest;
  logic        take_branch;

  assign opcode  = ifid_instr[OPCODE_MSB:OPCODE_LSB];
  assign src1    = ifid_instr[SRC1_MSB:SRC1_LSB];
  assign src2    = ifid_instr[SRC2_MSB:SRC2_LSB];
  assign rdst    = ifid_instr[RDST_MSB:RDST_LSB];
  assign imm_ext = sext16(ifid_instr[IMM_MSB:IMM_LSB]);

  register_file u_register_file (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (src1),
    .rd_addr2 (src2),
    .rd_data1 (rs1_val),
    .rd_data2 (rs2_val),
    .wr_en    (bus.wb_en),
    .wr_addr  (bus.wb_dest),
    .wr_data  (bus.wb_value)
  );

  // The instruction after a taken branch is already in fetch; drop it here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else begin
      ifid_valid <= !take_branch;
      ifid_pc    <= bus.if_pc;
      ifid_instr <= bus.if_instruction;
    end
  end

  always_comb begin
    dec_cmd       = CMD_ADD;
    dec_r_type    = 1'b0;
    dec_use_imm   = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_wb_en     = 1'b0;
    dec_dest      = '0;
    if (ifid_valid) begin
      case (opcode)
        OP_ADD:  begin dec_cmd = CMD_ADD; dec_r_type = 1'b1; end
        OP_SUB:  begin dec_cmd = CMD_SUB; dec_r_type = 1'b1; end
        OP_AND:  begin dec_cmd = CMD_AND; dec_r_type = 1'b1; end
        OP_OR:   begin dec_cmd = CMD_OR;  dec_r_type = 1'b1; end
        OP_NOR:  begin dec_cmd = CMD_NOR; dec_r_type = 1'b1; end
        OP_XOR:  begin dec_cmd = CMD_XOR; dec_r_type = 1'b1; end
        OP_SLA:  begin dec_cmd = CMD_SLA; dec_r_type = 1'b1; end
        OP_SLL:  begin dec_cmd = CMD_SLL; dec_r_type = 1'b1; end
        OP_SRA:  begin dec_cmd = CMD_SRA; dec_r_type = 1'b1; end
        OP_SRL:  begin dec_cmd = CMD_SRL; dec_r_type = 1'b1; end
        OP_ADDI: begin dec_use_imm = 1'b1; dec_wb_en = 1'b1; dec_dest = src2; end
        OP_SUBI: begin dec_cmd = CMD_SUB; dec_use_imm = 1'b1; dec_wb_en = 1'b1; dec_dest = src2; end
        OP_LD:   begin dec_use_imm = 1'b1; dec_mem_read = 1'b1; dec_wb_en = 1'b1; dec_dest = src2; end
        OP_ST:   begin dec_use_imm = 1'b1; dec_mem_write = 1'b1; end
        default: ;
      endcase
      if (dec_r_type) begin
        dec_wb_en = 1'b1;
        dec_dest  = rdst;
      end
    end
  end

  always_comb begin
    take_branch = 1'b0;
    if (ifid_valid) begin
      case (opcode)
        OP_BEZ:  take_branch = (rs1_val == 32'd0);
        OP_BNE:  take_branch = (rs1_val != rs2_val);
        OP_JMP:  take_branch = 1'b1;
        default: take_branch = 1'b0;
      endcase
    end
  end

  assign bus.branch_taken   = take_branch;
  assign bus.branch_address = ifid_pc + 32'd4 + {imm_ext[29:0], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ex_pc        <= '0;
      bus.ex_cmd       <= '0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_wb_en     <= 1'b0;
      bus.ex_dest      <= '0;
      bus.ex_val1      <= '0;
      bus.ex_val2      <= '0;
      bus.ex_st_val    <= '0;
    end else begin
      bus.ex_pc        <= ifid_pc;
      bus.ex_cmd       <= dec_cmd;
      bus.ex_mem_read  <= dec_mem_read;
      bus.ex_mem_write <= dec_mem_write;
      bus.ex_wb_en     <= dec_wb_en;
      bus.ex_dest      <= dec_dest;
      bus.ex_val1      <= rs1_val;
      bus.ex_val2      <= dec_use_imm ? imm_ext : rs2_val;
      bus.ex_st_val    <= dec_mem_write ? rs2_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued when an
// instruction is driven and checked two edges later; branch outputs checked in ID.
module tb_id_stage;
  import id_stage_pkg::*;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] st;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks;
  int   failures;
  int   cyc;
  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2);
    return {op, s1, s2, d, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [15:0] imm);
    return {op, s1, d, imm};
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{kind: 0, pc: '0, cmd: '0, v1: '0, v2: '0, dest: '0,
          wb: 1'b0, mr: 1'b0, mw: 1'b0, st: '0, due: 0};
    return e;
  endfunction

  function automatic exp_t make_exp(input int kind, input logic [31:0] pc, input logic [3:0] cmd,
                                    input logic [31:0] v1, input logic [31:0] v2,
                                    input logic [4:0] dest, input logic wb, input logic mr,
                                    input logic mw, input logic [31:0] st);
    exp_t e;
    e = '{kind: kind, pc: pc, cmd: cmd, v1: v1, v2: v2, dest: dest,
          wb: wb, mr: mr, mw: mw, st: st, due: 0};
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // kind 0 = bubble (only side-effect controls matter), 1 = writer, 2 = store
  task automatic compare_entry(input exp_t e);
    string t;
    t = $sformatf("pc%0d", e.pc);
    check_output({t, ".wb_en"},     32'(bus.ex_wb_en),     32'(e.wb));
    check_output({t, ".mem_read"},  32'(bus.ex_mem_read),  32'(e.mr));
    check_output({t, ".mem_write"}, 32'(bus.ex_mem_write), 32'(e.mw));
    if (e.kind != 0) begin
      check_output({t, ".ex_pc"},   bus.ex_pc,           e.pc);
      check_output({t, ".ex_cmd"},  32'(bus.ex_cmd),     32'(e.cmd));
      check_output({t, ".ex_val1"}, bus.ex_val1,         e.v1);
      check_output({t, ".ex_val2"}, bus.ex_val2,         e.v2);
    end
    if (e.kind == 1) check_output({t, ".ex_dest"},   32'(bus.ex_dest), 32'(e.dest));
    if (e.kind == 2) check_output({t, ".ex_st_val"}, bus.ex_st_val,    e.st);
  endtask

  task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic wen, input logic [4:0] wd,
                                input logic [31:0] wv, input exp_t e);
    exp_t pending;
    bus.if_instruction = instr;
    bus.if_pc          = pc;
    bus.wb_en          = wen;
    bus.wb_dest        = wd;
    bus.wb_value       = wv;
    pending            = e;
    pending.due        = cyc + 2;
    sb.push_back(pending);
    @(posedge clk);
    #1;
    cyc++;
    bus.wb_en = 1'b0;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t head;
      head = sb.pop_front();
      compare_entry(head);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, ".ex_pc"},        bus.ex_pc,                32'd0);
    check_output({tag, ".ex_cmd"},       32'(bus.ex_cmd),          32'd0);
    check_output({tag, ".ex_mem_read"},  32'(bus.ex_mem_read),     32'd0);
    check_output({tag, ".ex_mem_write"}, 32'(bus.ex_mem_write),    32'd0);
    check_output({tag, ".ex_wb_en"},     32'(bus.ex_wb_en),        32'd0);
    check_output({tag, ".ex_dest"},      32'(bus.ex_dest),         32'd0);
    check_output({tag, ".ex_val1"},      bus.ex_val1,              32'd0);
    check_output({tag, ".ex_val2"},      bus.ex_val2,              32'd0);
    check_output({tag, ".ex_st_val"},    bus.ex_st_val,            32'd0);
    check_output({tag, ".branch_taken"}, 32'(bus.branch_taken),    32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b0;
    bus.if_instruction = '0;
    bus.if_pc          = '0;
    bus.wb_en          = 1'b0;
    bus.wb_dest        = '0;
    bus.wb_value       = '0;

    #2;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    apply_stimulus(enc_i(OP_ADDI, 5'd1, 5'd0, 16'd1546), 32'd0, 1'b0, 5'd0, 32'd0,
                   make_exp(1, 32'd0, CMD_ADD, 32'd0, 32'd1546, 5'd1, 1'b1, 1'b0, 1'b0, 32'd0));
    check_output("first_edge.branch_taken", 32'(bus.branch_taken), 32'd0);
    apply_stimulus(enc_r(OP_ADD, 5'd2, 5'd0, 5'd1), 32'd4, 1'b0, 5'd0, 32'd0,
                   make_exp(1, 32'd4, CMD_ADD, 32'd0, 32'd1546, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0));
    apply_stimulus(32'd0, 32'd8,  1'b1, 5'd1, 32'd1546, bubble());
    apply_stimulus(32'd0, 32'd12, 1'b1, 5'd3, 32'd1,    bubble());
    apply_stimulus(32'd0, 32'd16, 1'b1, 5'd1, 32'd3,    bubble());

    apply_stimulus(enc_i(OP_BNE, 5'd3, 5'd1, 16'hFFDE), 32'd320, 1'b0, 5'd0, 32'd0, bubble());
    check_output("bne.branch_taken",   32'(bus.branch_taken), 32'd1);
    check_output("bne.branch_address", bus.branch_address,    32'd188);
    apply_stimulus(enc_i(OP_ADDI, 5'd4, 5'd0, 16'd7), 32'd324, 1'b0, 5'd0, 32'd0, bubble());
    check_output("squashed.branch_taken", 32'(bus.branch_taken), 32'd0);

    apply_stimulus(32'd0, 32'd188, 1'b1, 5'd5, 32'd1546, bubble());
    apply_stimulus(enc_i(OP_BEZ, 5'd0, 5'd5, 16'd1), 32'd192, 1'b0, 5'd0, 32'd0, bubble());
    check_output("bez.branch_taken", 32'(bus.branch_taken), 32'd0);
    apply_stimulus(enc_i(OP_ADDI, 5'd6, 5'd0, 16'hFFFE), 32'd196, 1'b0, 5'd0, 32'd0,
                   make_exp(1, 32'd196, CMD_ADD, 32'd0, 32'hFFFF_FFFE, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0));
    apply_stimulus(enc_r(OP_SUB, 5'd7, 5'd1, 5'd3), 32'd200, 1'b0, 5'd0, 32'd0,
                   make_exp(1, 32'd200, CMD_SUB, 32'd3, 32'd1, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0));
    apply_stimulus(enc_r(OP_SRL, 5'd9, 5'd1, 5'd3), 32'd204, 1'b0, 5'd0, 32'd0,
                   make_exp(1, 32'd204, CMD_SRL, 32'd3, 32'd1, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0));

    apply_stimulus(32'd0, 32'd208, 1'b1, 5'd0, 32'd5, bubble());
    apply_stimulus(enc_r(OP_ADD, 5'd2, 5'd0, 5'd0), 32'd212, 1'b1, 5'd0, 32'd5,
                   make_exp(1, 32'd212, CMD_ADD, 32'd0, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0));
    apply_stimulus(enc_r(6'd63, 5'd4, 5'd1, 5'd3), 32'd216, 1'b1, 5'd0, 32'd5, bubble());
    apply_stimulus(enc_i(OP_LD, 5'd8, 5'd1, 16'd8), 32'd220, 1'b0, 5'd0, 32'd0,
                   make_exp(1, 32'd220, CMD_ADD, 32'd3, 32'd8, 5'd8, 1'b1, 1'b1, 1'b0, 32'd0));

    apply_stimulus(enc_i(OP_JMP, 5'd0, 5'd0, 16'd4), 32'd224, 1'b0, 5'd0, 32'd0, bubble());
    check_output("jmp.branch_taken",   32'(bus.branch_taken), 32'd1);
    check_output("jmp.branch_address", bus.branch_address,    32'd244);
    apply_stimulus(enc_r(OP_XOR, 5'd10, 5'd1, 5'd3), 32'd228, 1'b0, 5'd0, 32'd0, bubble());
    apply_stimulus(enc_i(OP_ST, 5'd3, 5'd1, 16'hFFFC), 32'd244, 1'b0, 5'd0, 32'd0,
                   make_exp(2, 32'd244, CMD_ADD, 32'd3, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0, 1'b1, 32'd1));
    apply_stimulus(32'd0, 32'd248, 1'b0, 5'd0, 32'd0, bubble());
    apply_stimulus(32'd0, 32'd252, 1'b0, 5'd0, 32'd0, bubble());

    // Store reaches ID/EX, then reset hits mid-cycle with a write-back pending.
    apply_stimulus(enc_i(OP_ST, 5'd3, 5'd1, 16'd12), 32'd256, 1'b0, 5'd0, 32'd0,
                   make_exp(2, 32'd256, CMD_ADD, 32'd3, 32'd12, 5'd0, 1'b0, 1'b0, 1'b1, 32'd1));
    apply_stimulus(32'd0, 32'd260, 1'b0, 5'd0, 32'd0, bubble());
    bus.wb_en    = 1'b1;
    bus.wb_dest  = 5'd1;
    bus.wb_value = 32'd99;
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("mid_st_reset");
    sb.delete();
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
    rst       = 1'b1;
    check_output("post_reset.branch_taken", 32'(bus.branch_taken), 32'd0);

    apply_stimulus(enc_r(OP_ADD, 5'd10, 5'd1, 5'd3), 32'd0, 1'b0, 5'd0, 32'd0,
                   make_exp(1, 32'd0, CMD_ADD, 32'd0, 32'd0, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0));
    apply_stimulus(32'd0, 32'd4, 1'b0, 5'd0, 32'd0, bubble());
    apply_stimulus(32'd0, 32'd8, 1'b0, 5'd0, 32'd0, bubble());
    apply_stimulus(32'd0, 32'd12, 1'b0, 5'd0, 32'd0, bubble());

    check_output("scoreboard_drained", 32'(sb.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
